deemph_mc: RTL and testbench
============================

# deemph_mc

Multi-channel FM de-emphasis filter: a first-order fixed-point IIR (two feed-forward taps, one feedback tap) applied independently to CHANNELS time-interleaved sample streams. It sits after the demodulator/stereo separation stage and feeds the audio decimator. Input and output are each buffered by the codebase's `fifo` module. The block generalises the single-channel de-emphasis top with per-channel history, parametrised coefficients and optional output saturation.

## Interface

Parameters:
- DATA_WIDTH, 32, sample width (signed two's complement)
- FIFO_BUFFER_SIZE, 8, depth of the input FIFO and of the output FIFO
- CHANNELS, 2, number of interleaved channels (1..16)
- FRAC_BITS, 10, coefficient fractional bits (dequantise shift)
- B0, 32'h000000B2, coefficient on x[n]
- B1, 32'h000000B2, coefficient on x[n-1]
- A1, 32'hFFFFFD66, coefficient on y[n-1] (added as stored)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_wr_en  in  1  push in_din into the input FIFO
- in_din  in  DATA_WIDTH  input sample; channel order 0,1,..,CHANNELS-1, repeating
- in_full  out  1  input FIFO full
- out_rd_en  in  1  pop the output FIFO
- out_dout  out  DATA_WIDTH  output sample, show-ahead (valid whenever out_empty=0)
- out_empty  out  1  output FIFO empty

## Operation

- Per channel c: y[n] = q(B0*x[n]) + q(B1*x[n-1]) + q(A1*y[n-1]). Products are signed 2*DATA_WIDTH bits; q() divides by 2^FRAC_BITS, truncating toward zero (C integer-division semantics). The result is bit-exact with the golden C model.
- History x_prev[c] and y_prev[c] are DATA_WIDTH registers per channel, all zero after reset.
- Sum is formed at DATA_WIDTH+2 bits. Without saturation the low DATA_WIDTH bits are kept (wrap). y_prev stores the value actually emitted.
- Channel index ch counts 0..CHANNELS-1 and wraps to 0. It advances once per emitted sample.
- FSM:
  - S_IDLE: if input FIFO not empty and output FIFO not full, pop one sample, latch x, go to S_MUL. Otherwise stay.
  - S_MUL: register the three products for channel ch, go to S_ACC.
  - S_ACC: dequantise and sum; push y into the output FIFO; update x_prev[ch]=x, y_prev[ch]=y; advance ch; go to S_IDLE.
- Samples are never dropped or duplicated. A pop occurs only when a slot in the output FIFO is guaranteed.
- Writes to a full input FIFO and reads from an empty output FIFO are ignored (FIFO protects itself). The stream is not corrupted.

## Timing

- Reset: out_empty=1, in_full=0, out_dout=0, FSM=S_IDLE, ch=0, all history 0, both FIFOs flushed.
- Reset asserted mid-operation discards the in-flight sample and all buffered samples. The first sample after reset is treated as channel 0 with zero history.
- Throughput: one sample per 3 cycles.
- Latency: in_wr_en sampled at edge k with an empty pipeline gives out_empty=0 after edge k+3.
- Simultaneous push and pop on either FIFO are both honoured.
- Output FIFO full stalls the FSM in S_IDLE; the input FIFO then fills and in_full asserts. Both release the cycle after out_rd_en frees a slot.

## Configuration

- DEEMPH_SAT_EN defined: the DATA_WIDTH+2-bit sum clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before output and history update.
- Not defined: the sum wraps to DATA_WIDTH bits. No saturation logic is built.

## Test plan

- Reset: after one reset cycle, out_empty=1 and in_full=0. No output appears with no input.
- Impulse, CHANNELS=1, default coefficients: input 1024,0,0 -> output 178, 63, -40.
- Interleave, CHANNELS=2: input 1024,0,0,0 -> output 178,0,63,0. Confirms channels are independent.
- Backpressure, FIFO_BUFFER_SIZE=8: push 64 golden samples with out_rd_en held at 0. in_full asserts, no push is lost, and draining yields all 64 golden outputs with 0 errors.
- Reset mid-stream: input 1024 -> 178; pulse reset for one cycle; input 0 -> output 0 (history cleared).
- Saturation, B0=B1=32'h400, A1=0, CHANNELS=1: input 32'h7FFFFFFF twice -> second output 32'h7FFFFFFF with DEEMPH_SAT_EN, 32'hFFFFFFFE without.

Source files
------------

// File: rtl/deemph_mc_if.sv
// rtl/deemph_mc_if.sv - sample stream bus of deemph_mc: input FIFO write side and output FIFO read side
interface deemph_mc_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_wr_en;
  logic [DATA_WIDTH-1:0] in_din;
  logic                  in_full;
  logic                  out_rd_en;
  logic [DATA_WIDTH-1:0] out_dout;
  logic                  out_empty;

  modport master (
    output in_wr_en, in_din, out_rd_en,
    input  in_full, out_dout, out_empty
  );

  modport slave (
    input  in_wr_en, in_din, out_rd_en,
    output in_full, out_dout, out_empty
  );
endinterface

// File: rtl/deemph_mc.sv
// rtl/deemph_mc.sv - multi-channel first-order IIR de-emphasis between two show-ahead FIFOs; DEEMPH_SAT_EN enables output saturation
module deemph_mc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Illegal requests (write when full, read when empty) are dropped here.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // Storage write port.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push and pop in the same cycle are both honoured.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module deemph_mc #(
  parameter int          DATA_WIDTH       = 32,
  parameter int          FIFO_BUFFER_SIZE = 8,
  parameter int          CHANNELS         = 2,
  parameter int          FRAC_BITS        = 10,
  parameter logic [31:0] B0               = 32'h000000B2,
  parameter logic [31:0] B1               = 32'h000000B2,
  parameter logic [31:0] A1               = 32'hFFFFFD66
) (
  input logic         clock,
  input logic         reset,
  deemph_mc_if.slave  bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = 2 * DATA_WIDTH;
`ifdef DEEMPH_SAT_EN
  // Two guard bits so the clamp sees the true sign and magnitude of the sum.
  localparam int SW = DATA_WIDTH + 2;
  localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};
`else
  // Wrapping keeps only the low DATA_WIDTH bits, so the sum is formed at that width.
  localparam int SW = DATA_WIDTH;
`endif

  localparam logic signed [DATA_WIDTH-1:0] K_B0 = DATA_WIDTH'(signed'(B0));
  localparam logic signed [DATA_WIDTH-1:0] K_B1 = DATA_WIDTH'(signed'(B1));
  localparam logic signed [DATA_WIDTH-1:0] K_A1 = DATA_WIDTH'(signed'(A1));
  localparam logic signed [PW-1:0]         BIAS = PW'((1 << FRAC_BITS) - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  logic [1:0]                   state;
  logic [CW-1:0]                ch;
  logic signed [DATA_WIDTH-1:0] x_cur;
  logic signed [DATA_WIDTH-1:0] x_prev [CHANNELS];
  logic signed [DATA_WIDTH-1:0] y_prev [CHANNELS];
  logic signed [PW-1:0]         p_b0;
  logic signed [PW-1:0]         p_b1;
  logic signed [PW-1:0]         p_a1;
  logic signed [SW-1:0]         sum;
  logic signed [DATA_WIDTH-1:0] y_out;

  logic [DATA_WIDTH-1:0] in_dout;
  logic                  in_empty;
  logic                  in_pop;
  logic                  out_full;
  logic                  out_push;

  // Divide by 2^FRAC_BITS rounding toward zero: negative products get a bias before the arithmetic shift.
  function automatic logic signed [SW-1:0] dequant(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = p[PW-1] ? (p + BIAS) : p;
    t = t >>> FRAC_BITS;
    return t[SW-1:0];
  endfunction

  deemph_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_in_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (bus.in_wr_en),
    .din   (bus.in_din),
    .full  (bus.in_full),
    .rd_en (in_pop),
    .dout  (in_dout),
    .empty (in_empty)
  );

  deemph_mc_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_BUFFER_SIZE)) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .wr_en (out_push),
    .din   (y_out),
    .full  (out_full),
    .rd_en (bus.out_rd_en),
    .dout  (bus.out_dout),
    .empty (bus.out_empty)
  );

  // Only one sample is ever in flight, so a free output slot seen in S_IDLE is still free in S_ACC.
  assign in_pop   = (state == S_IDLE) && !in_empty && !out_full;
  assign out_push = (state == S_ACC);

  // Dequantise, sum and (optionally) clamp the registered products.
  always_comb begin
    sum   = dequant(p_b0) + dequant(p_b1) + dequant(p_a1);
    y_out = sum[DATA_WIDTH-1:0];
`ifdef DEEMPH_SAT_EN
    if (sum > SAT_MAX)      y_out = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum < SAT_MIN) y_out = SAT_MIN[DATA_WIDTH-1:0];
`endif
  end

  // Three-state sequencer: fetch a sample, multiply against channel history, emit and update history.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ch    <= '0;
      x_cur <= '0;
      p_b0  <= '0;
      p_b1  <= '0;
      p_a1  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        x_prev[i] <= '0;
        y_prev[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_pop) begin
            x_cur <= in_dout;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          p_b0  <= PW'(x_cur) * PW'(K_B0);
          p_b1  <= PW'(x_prev[ch]) * PW'(K_B1);
          p_a1  <= PW'(y_prev[ch]) * PW'(K_A1);
          state <= S_ACC;
        end
        S_ACC: begin
          x_prev[ch] <= x_cur;
          y_prev[ch] <= y_out;
          ch         <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + CW'(1);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_deemph_mc.sv
// tb/tb_deemph_mc.sv - directed self-checking bench for deemph_mc with an arithmetic reference model
module tb_deemph_mc;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  deemph_mc_if #(.DATA_WIDTH(32)) bus0 ();
  deemph_mc_if #(.DATA_WIDTH(32)) bus1 ();
  deemph_mc_if #(.DATA_WIDTH(32)) bus2 ();

  deemph_mc #(.CHANNELS(2)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  deemph_mc #(.CHANNELS(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  deemph_mc #(.CHANNELS(1), .B0(32'h400), .B1(32'h400), .A1(32'h0)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  int tests = 0;
  int fails = 0;

  // Reference model state per DUT instance
  longint cb0 [3] = '{178, 178, 1024};
  longint cb1 [3] = '{178, 178, 1024};
  longint ca1 [3] = '{-666, -666, 0};
  int     nch [3] = '{2, 1, 1};
  longint xp [3][16];
  longint yp [3][16];
  int     mch [3];

  logic [31:0] exp0[$], exp1[$], exp2[$];
  logic [31:0] got0[$], got1[$], got2[$];

  logic [31:0] vtab [8] = '{32'd1024, 32'hFFFFFC00, 32'd0, 32'h7FFFFFFF,
                            32'h80000000, 32'd123456, 32'hFFF0BDC0, 32'd55};

  function automatic logic [31:0] model_step(input int d, input logic [31:0] xin);
    longint x, s;
    logic [31:0] y;
    x = longint'($signed(xin));
    s = (cb0[d] * x) / 1024 + (cb1[d] * xp[d][mch[d]]) / 1024 + (ca1[d] * yp[d][mch[d]]) / 1024;
    s = (s <<< 30) >>> 30;
`ifdef DEEMPH_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    y = s[31:0];
    xp[d][mch[d]] = x;
    yp[d][mch[d]] = longint'($signed(y));
    mch[d] = (mch[d] + 1) % nch[d];
    return y;
  endfunction

  function automatic logic full_of(input int d);
    case (d)
      0:       return bus0.in_full;
      1:       return bus1.in_full;
      default: return bus2.in_full;
    endcase
  endfunction

  function automatic int pending();
    return exp0.size() + exp1.size() + exp2.size();
  endfunction

  task automatic set_in(input int d, input logic en, input logic [31:0] x);
    case (d)
      0:       begin bus0.in_wr_en = en; bus0.in_din = x; end
      1:       begin bus1.in_wr_en = en; bus1.in_din = x; end
      default: begin bus2.in_wr_en = en; bus2.in_din = x; end
    endcase
  endtask

  task automatic set_rd(input logic v);
    bus0.out_rd_en = v;
    bus1.out_rd_en = v;
    bus2.out_rd_en = v;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_pop(input int d, input logic [31:0] v);
    logic [31:0] e;
    int n;
    case (d)
      0:       n = exp0.size();
      1:       n = exp1.size();
      default: n = exp2.size();
    endcase
    tests++;
    if (n == 0) begin
      fails++;
      $display("FAIL stream_extra dut%0d: got %h, required no output", d, v);
    end else begin
      case (d)
        0:       e = exp0.pop_front();
        1:       e = exp1.pop_front();
        default: e = exp2.pop_front();
      endcase
      if (v !== e) begin
        fails++;
        $display("FAIL stream dut%0d: got %h, required %h", d, v, e);
      end
    end
    case (d)
      0:       got0.push_back(v);
      1:       got1.push_back(v);
      default: got2.push_back(v);
    endcase
  endtask

  // Every popped output word is compared against the model
  always @(negedge clock) begin
    if (bus0.out_rd_en && !bus0.out_empty) check_pop(0, bus0.out_dout);
    if (bus1.out_rd_en && !bus1.out_empty) check_pop(1, bus1.out_dout);
    if (bus2.out_rd_en && !bus2.out_empty) check_pop(2, bus2.out_dout);
  end

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    set_in(2, 1'b0, '0);
    set_rd(1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      mch[d] = 0;
      for (int c = 0; c < 16; c++) begin
        xp[d][c] = 0;
        yp[d][c] = 0;
      end
    end
    exp0.delete(); exp1.delete(); exp2.delete();
    got0.delete(); got1.delete(); got2.delete();
  endtask

  task automatic push(input int d, input logic [31:0] x);
    int waited = 0;
    logic [31:0] y;
    while (full_of(d) && waited < 200) begin
      @(posedge clock); #1;
      waited++;
    end
    tests++;
    if (full_of(d)) begin
      fails++;
      $display("FAIL push_timeout dut%0d: in_full=1 after %0d cycles, required 0", d, waited);
    end else begin
      set_in(d, 1'b1, x);
      y = model_step(d, x);
      case (d)
        0:       exp0.push_back(y);
        1:       exp1.push_back(y);
        default: exp2.push_back(y);
      endcase
      @(posedge clock); #1;
      set_in(d, 1'b0, '0);
    end
  endtask

  task automatic drain();
    int budget = 0;
    set_rd(1'b1);
    while (pending() != 0 && budget < 600) begin
      @(posedge clock); #1;
      budget++;
    end
    tests++;
    if (pending() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d outputs missing, required 0", pending());
    end
    repeat (6) @(posedge clock);
    #1;
    set_rd(1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    set_in(2, 1'b0, '0);
    set_rd(1'b0);
    @(posedge clock); #1;
    do_reset();

    // Reset state and idle behaviour
    chk("rst_out_empty", 32'(bus0.out_empty), 32'd1);
    chk("rst_in_full", 32'(bus0.in_full), 32'd0);
    chk("rst_out_dout", bus0.out_dout, 32'd0);
    chk("rst_out_empty_dut1", 32'(bus1.out_empty), 32'd1);
    chk("rst_out_empty_dut2", 32'(bus2.out_empty), 32'd1);
    repeat (10) @(posedge clock);
    #1;
    chk("idle_out_empty", 32'(bus0.out_empty), 32'd1);

    // Latency: push at edge k, output visible after edge k+3
    push(0, 32'd1024);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("lat_empty_k2", 32'(bus0.out_empty), 32'd1);
    @(posedge clock); #1;
    chk("lat_empty_k3", 32'(bus0.out_empty), 32'd0);
    chk("lat_dout_k3", bus0.out_dout, 32'd178);
    drain();

    // Impulse on a single channel
    push(1, 32'd1024);
    push(1, 32'd0);
    push(1, 32'd0);
    drain();
    chk("imp_count", 32'(got1.size()), 32'd3);
    if (got1.size() >= 3) begin
      chk("imp_y0", got1[0], 32'd178);
      chk("imp_y1", got1[1], 32'd63);
      chk("imp_y2", got1[2], 32'hFFFFFFD8);
    end

    // Two interleaved channels stay independent
    do_reset();
    push(0, 32'd1024);
    push(0, 32'd0);
    push(0, 32'd0);
    push(0, 32'd0);
    drain();
    chk("ilv_count", 32'(got0.size()), 32'd4);
    if (got0.size() >= 4) begin
      chk("ilv_y0", got0[0], 32'd178);
      chk("ilv_y1", got0[1], 32'd0);
      chk("ilv_y2", got0[2], 32'd63);
      chk("ilv_y3", got0[3], 32'd0);
    end

    // Backpressure: fill both FIFOs with the reader stalled
    do_reset();
    for (int i = 0; i < 16; i++) push(0, vtab[i % 8] + 32'(i * 7919));
    repeat (12) @(posedge clock);
    #1;
    chk("bp_in_full", 32'(bus0.in_full), 32'd1);
    chk("bp_out_nonempty", 32'(bus0.out_empty), 32'd0);
    set_in(0, 1'b1, 32'h12345678);
    @(posedge clock); #1;
    set_in(0, 1'b0, '0);
    bus0.out_rd_en = 1'b1;
    @(posedge clock); #1;
    bus0.out_rd_en = 1'b0;
    chk("bp_full_hold", 32'(bus0.in_full), 32'd1);
    @(posedge clock); #1;
    chk("bp_full_release", 32'(bus0.in_full), 32'd0);
    bus0.out_rd_en = 1'b1;
    for (int i = 16; i < 64; i++) push(0, vtab[i % 8] + 32'(i * 7919));
    drain();
    chk("bp_count", 32'(got0.size()), 32'd64);

    // Reset in the middle of a stream clears history and in-flight data
    do_reset();
    push(0, 32'd1024);
    drain();
    if (got0.size() >= 1) chk("mid_first", got0[0], 32'd178);
    push(0, 32'd0);
    do_reset();
    drain();
    chk("mid_no_stale", 32'(got0.size()), 32'd0);
    push(0, 32'd0);
    drain();
    chk("mid_count", 32'(got0.size()), 32'd1);
    if (got0.size() >= 1) chk("mid_zero", got0[0], 32'd0);

    // Overflow of the sum: clamp or wrap depending on build
    push(2, 32'h7FFFFFFF);
    push(2, 32'h7FFFFFFF);
    drain();
    chk("sat_count", 32'(got2.size()), 32'd2);
    if (got2.size() >= 2) begin
      chk("sat_y0", got2[0], 32'h7FFFFFFF);
`ifdef DEEMPH_SAT_EN
      chk("sat_y1", got2[1], 32'h7FFFFFFF);
`else
      chk("sat_y1", got2[1], 32'hFFFFFFFE);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
